// File: rtl/mem_pkg.sv
// Shared definitions for the data-port responder: bus widths, the responder
// state encoding and the byte-enable merge helper used by the storage.
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

package mem_pkg;

  localparam int ADDR_W = `DRAM_ADDRESS_SIZE;
  localparam int WORD_W = `DRAM_WORD_SIZE;
  localparam int BE_W   = WORD_W / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    RESP      = 2'd2,
    WAIT_DROP = 2'd3
  } resp_state_e;

  // Replace only the bytes of old_word whose enable bit is set.
  function automatic logic [WORD_W-1:0] be_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/be_sram.sv
// Word-organised storage with one byte-enabled write port and one
// synchronous read port. The array itself is never reset; only the read
// data register is cleared by reset.
//   clock, reset      : clock and synchronous active-high reset
//   wr_en/wr_idx      : write strobe and word index
//   wr_data/wr_be     : write word and per-byte enables
//   rd_en/rd_idx      : read strobe and word index
//   rd_data           : registered read word, held until the next rd_en
import mem_pkg::*;

module be_sram #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem_r [DEPTH];

  // Byte-enabled write into the array.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_idx] <= be_merge(mem_r[wr_idx], wr_data, wr_be);
    end
  end

  // Synchronous read; the register holds its value between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem_r[rd_idx];
    end
  end

endmodule

// File: rtl/config.sv
// Project-wide bus widths shared by the memory-side blocks.
//   DRAM_ADDRESS_SIZE : width of a CPU byte address
//   DRAM_WORD_SIZE    : width of one data word (a multiple of 8)
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

// File: rtl/data_port_responder.sv
// Fixed-latency responder for the CPU data-cache port. A request is captured
// in IDLE, counted down in BUSY and completed with a one-cycle RESP carrying
// dcache_data_ready. A request still held after completion parks the FSM in
// WAIT_DROP so it is never served twice.
//   clock, reset          : clock and synchronous active-high reset
//   dcache_address        : CPU byte address (word index = bits [IDX_W+1:2])
//   dcache_dataRequest    : level request, held until ready
//   dcache_rw             : 1 = write, 0 = read
//   dcache_writeData      : write word
//   dcache_byte_en        : per-byte write enables (ignored on reads)
//   dcache_readData       : last read word, updated at each read's RESP
//   dcache_data_ready     : one-cycle completion pulse
//   transfer_in_progress  : high in BUSY and RESP
import mem_pkg::*;

module data_port_responder #(
  parameter int LATENCY     = 3,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic              dcache_dataRequest,
  input  logic              dcache_rw,
  input  logic [WORD_W-1:0] dcache_writeData,
  input  logic [BE_W-1:0]   dcache_byte_en,
  output logic [WORD_W-1:0] dcache_readData,
  output logic              dcache_data_ready,
  output logic              transfer_in_progress
);

  localparam int               IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LOAD_CNT    = CNT_W'(LATENCY - 1);
  // With LATENCY=1 the capture edge itself moves straight into RESP.
  localparam bit               DIRECT_RESP = (LATENCY == 1);

  resp_state_e       state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic              rw_r;
  logic [WORD_W-1:0] wdata_r;
  logic [BE_W-1:0]   be_r;
  logic              ready_r;
  logic              tip_r;

  logic [IDX_W-1:0]  req_idx_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              enter_resp_s;
  logic              resp_is_read_s;
  logic              rd_en_s;
  logic              wr_en_s;
  logic              unused_addr_s;

  assign req_idx_s     = dcache_address[IDX_W+1:2];
  assign unused_addr_s = ^{dcache_address[ADDR_W-1:IDX_W+2], dcache_address[1:0]};

  // Detect the edge that enters RESP so the read is launched in time for
  // its data to be visible during RESP.
  always_comb begin
    enter_resp_s   = 1'b0;
    resp_is_read_s = 1'b0;
    rd_idx_s       = idx_r;
    case (state_r)
      IDLE: begin
        if (dcache_dataRequest && DIRECT_RESP) begin
          enter_resp_s   = 1'b1;
          resp_is_read_s = !dcache_rw;
          rd_idx_s       = req_idx_s;
        end else begin
          enter_resp_s   = 1'b0;
          resp_is_read_s = 1'b0;
          rd_idx_s       = idx_r;
        end
      end
      BUSY: begin
        if (cnt_r <= 4'd1) begin
          enter_resp_s   = 1'b1;
          resp_is_read_s = !rw_r;
        end else begin
          enter_resp_s   = 1'b0;
          resp_is_read_s = 1'b0;
        end
      end
      default: begin
        enter_resp_s   = 1'b0;
        resp_is_read_s = 1'b0;
      end
    endcase
    rd_en_s = enter_resp_s && resp_is_read_s && !reset;
    // The write lands at the edge that ends RESP; a reset at that edge wins.
    wr_en_s = (state_r == RESP) && rw_r && !reset;
  end

  // Request FSM, latency counter, captured request and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      rw_r    <= 1'b0;
      wdata_r <= '0;
      be_r    <= '0;
      ready_r <= 1'b0;
      tip_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (dcache_dataRequest) begin
            idx_r   <= req_idx_s;
            rw_r    <= dcache_rw;
            wdata_r <= dcache_writeData;
            be_r    <= dcache_byte_en;
            tip_r   <= 1'b1;
            if (DIRECT_RESP) begin
              state_r <= RESP;
              cnt_r   <= '0;
              ready_r <= 1'b1;
            end else begin
              state_r <= BUSY;
              cnt_r   <= LOAD_CNT;
              ready_r <= 1'b0;
            end
          end else begin
            tip_r   <= 1'b0;
            ready_r <= 1'b0;
          end
        end
        BUSY: begin
          tip_r <= 1'b1;
          if (enter_resp_s) begin
            state_r <= RESP;
            cnt_r   <= '0;
            ready_r <= 1'b1;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
            ready_r <= 1'b0;
          end
        end
        RESP: begin
          ready_r <= 1'b0;
          tip_r   <= 1'b0;
          if (dcache_dataRequest) begin
            state_r <= WAIT_DROP;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_DROP: begin
          ready_r <= 1'b0;
          tip_r   <= 1'b0;
          if (!dcache_dataRequest) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_DROP;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          tip_r   <= 1'b0;
        end
      endcase
    end
  end

  be_sram #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_sram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_idx  (idx_r),
    .wr_data (wdata_r),
    .wr_be   (be_r),
    .rd_en   (rd_en_s),
    .rd_idx  (rd_idx_s),
    .rd_data (dcache_readData)
  );

  assign dcache_data_ready    = ready_r;
  assign transfer_in_progress = tip_r;

endmodule

// File: tb/tb_data_port_responder.sv
// Scoreboard bench for data_port_responder (LATENCY=3, 32-bit words).
// The driver pushes the expected read data and the capture cycle for every
// access; an independent monitor pops one entry per ready pulse and checks
// data, latency and the number of transfer_in_progress cycles.
import mem_pkg::*;

module tb_data_port_responder;

  localparam int LAT = 3;

  typedef struct {
    logic [31:0] data;
    int          cap;
    string       name;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] dcache_address;
  logic              dcache_dataRequest;
  logic              dcache_rw;
  logic [WORD_W-1:0] dcache_writeData;
  logic [BE_W-1:0]   dcache_byte_en;
  logic [WORD_W-1:0] dcache_readData;
  logic              dcache_data_ready;
  logic              transfer_in_progress;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   resp_count = 0;
  int   tip_run = 0;
  exp_t sb[$];

  data_port_responder #(.LATENCY(LAT), .DEPTH_WORDS(1024)) dut (
    .clock                (clock),
    .reset                (reset),
    .dcache_address       (dcache_address),
    .dcache_dataRequest   (dcache_dataRequest),
    .dcache_rw            (dcache_rw),
    .dcache_writeData     (dcache_writeData),
    .dcache_byte_en       (dcache_byte_en),
    .dcache_readData      (dcache_readData),
    .dcache_data_ready    (dcache_data_ready),
    .transfer_in_progress (transfer_in_progress)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: one scoreboard entry per ready pulse.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      tip_run = 0;
    end else begin
      if (transfer_in_progress) tip_run++;
      if (dcache_data_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ready: got ready at cycle %0d, expected no pulse", cyc);
        end else begin
          e = sb.pop_front();
          total++;
          if (dcache_readData !== e.data) begin
            bad++;
            $display("FAIL %s readData: got %08h expected %08h", e.name, dcache_readData, e.data);
          end
          // Ready is consumed at the next rising edge, LAT edges after capture.
          total++;
          if (cyc + 1 - e.cap != LAT) begin
            bad++;
            $display("FAIL %s latency: got %0d expected %0d", e.name, cyc + 1 - e.cap, LAT);
          end
          total++;
          if (tip_run != LAT) begin
            bad++;
            $display("FAIL %s tip_cycles: got %0d expected %0d", e.name, tip_run, LAT);
          end
        end
        tip_run = 0;
        resp_count++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic access(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd, input string name,
                        input int hold, input bit scramble);
    int   start_resp;
    bit   got;
    exp_t e;
    @(negedge clock);
    dcache_address     = addr;
    dcache_rw          = rw;
    dcache_writeData   = wdata;
    dcache_byte_en     = be;
    dcache_dataRequest = 1'b1;
    start_resp = resp_count;
    @(posedge clock);
    #1;
    e.data = exp_rd;
    e.cap  = cyc;
    e.name = name;
    sb.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      #1;
      if (resp_count != start_resp) begin
        got = 1'b1;
      end else if (scramble) begin
        dcache_address   = addr + 32'(16 * (k + 1));
        dcache_writeData = wdata ^ 32'hFFFF0000 ^ 32'(k + 1);
        dcache_rw        = ~rw;
        dcache_byte_en   = ~be;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout: got no ready within 40 cycles, expected ready", name);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      #1;
      total++;
      if (transfer_in_progress !== 1'b0 || dut.state_r != WAIT_DROP) begin
        bad++;
        $display("FAIL %s hold%0d: got tip=%0b state=%0d expected tip=0 state=%0d",
                 name, h, transfer_in_progress, dut.state_r, WAIT_DROP);
      end
    end
    dcache_dataRequest = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    dcache_address     = '0;
    dcache_dataRequest = 1'b0;
    dcache_rw          = 1'b0;
    dcache_writeData   = '0;
    dcache_byte_en     = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_ready", {31'd0, dcache_data_ready}, 32'd0);
    check("reset_tip", {31'd0, transfer_in_progress}, 32'd0);
    check("reset_rdata", dcache_readData, 32'h00000000);
    reset = 1'b0;

    // Full write then read, partial write, zero byte-enable write.
    access(32'h40, 1'b1, 32'hDEADBEEF, 4'b1111, 32'h00000000, "w40_full", 0, 1'b0);
    access(32'h40, 1'b0, 32'h0,        4'b0000, 32'hDEADBEEF, "r40_full", 0, 1'b0);
    access(32'h40, 1'b1, 32'h00001122, 4'b0011, 32'hDEADBEEF, "w40_part", 0, 1'b0);
    access(32'h40, 1'b0, 32'h0,        4'b1111, 32'hDEAD1122, "r40_part", 0, 1'b0);
    access(32'h40, 1'b1, 32'hFFFFFFFF, 4'b0000, 32'hDEAD1122, "w40_be0",  0, 1'b0);
    access(32'h40, 1'b0, 32'h0,        4'b0000, 32'hDEAD1122, "r40_be0",  0, 1'b0);

    // Request held 6 cycles past ready: single pulse, parked in WAIT_DROP.
    access(32'h40, 1'b0, 32'h0, 4'b0000, 32'hDEAD1122, "r40_hold", 6, 1'b0);

    // Address aliasing and ignored low address bits.
    access(32'h1000, 1'b1, 32'hA5A5A5A5, 4'b1111, 32'hDEAD1122, "w1000",   0, 1'b0);
    access(32'h0000, 1'b0, 32'h0,        4'b0000, 32'hA5A5A5A5, "r0000",   0, 1'b0);
    access(32'h0003, 1'b0, 32'h0,        4'b0000, 32'hA5A5A5A5, "r0003",   0, 1'b0);

    // Inputs scrambled during BUSY: only captured values matter.
    access(32'h44, 1'b1, 32'h11223344, 4'b1111, 32'hA5A5A5A5, "w44_scr", 0, 1'b1);
    access(32'h44, 1'b0, 32'h0,        4'b0000, 32'h11223344, "r44_scr", 0, 1'b1);
    access(32'h40, 1'b0, 32'h0,        4'b0000, 32'hDEAD1122, "r40_keep", 0, 1'b0);

    // Write aborted by reset one cycle after capture.
    access(32'h80, 1'b1, 32'h0BADF00D, 4'b1111, 32'hDEAD1122, "w80_old", 0, 1'b0);
    access(32'h80, 1'b0, 32'h0,        4'b0000, 32'h0BADF00D, "r80_old", 0, 1'b0);
    @(negedge clock);
    dcache_address     = 32'h80;
    dcache_rw          = 1'b1;
    dcache_writeData   = 32'h12345678;
    dcache_byte_en     = 4'b1111;
    dcache_dataRequest = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset              = 1'b1;
    dcache_dataRequest = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #1;
    check("abort_ready", {31'd0, dcache_data_ready}, 32'd0);
    check("abort_tip", {31'd0, transfer_in_progress}, 32'd0);
    check("abort_rdata", dcache_readData, 32'h00000000);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    access(32'h80, 1'b0, 32'h0,        4'b0000, 32'h0BADF00D, "r80_after", 0, 1'b0);
    access(32'h84, 1'b1, 32'hCAFEF00D, 4'b1111, 32'h0BADF00D, "w84",       0, 1'b0);
    access(32'h84, 1'b0, 32'h0,        4'b0000, 32'hCAFEF00D, "r84",       0, 1'b0);

    repeat (6) @(negedge clock);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
